// File: rtl/ks_note_sequencer.sv
// ks_note_sequencer: steps an 8-entry pattern table, loading the string period and plucking at tempo-timed intervals.
module ks_note_sequencer #(
  parameter int KS_DATA_WIDTH = 8,
  parameter int KS_MAX_LENGTH = 48,
  parameter int KS_MIN_LENGTH = 2,
  parameter int STEP_AW       = 3,
  parameter int TEMPO_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     seq_en,
  input  logic                     sample_tick,
  input  logic [TEMPO_WIDTH-1:0]   tempo,
  input  logic [STEP_AW-1:0]       last_step,
  input  logic                     tbl_we,
  input  logic [STEP_AW-1:0]       tbl_addr,
  input  logic [KS_DATA_WIDTH-1:0] tbl_wdata,
  output logic [KS_DATA_WIDTH-1:0] ks_period,
  output logic                     ks_pluck,
  output logic [STEP_AW-1:0]       step_idx,
  output logic                     busy
);
  localparam int CW = TEMPO_WIDTH + 4;
  localparam int NS = 1 << STEP_AW;
  localparam logic [KS_DATA_WIDTH-1:0] REST_ENTRY = {1'b1, {(KS_DATA_WIDTH-1){1'b0}}};
  localparam logic [KS_DATA_WIDTH-1:0] MAX_P = KS_DATA_WIDTH'(KS_MAX_LENGTH);
  localparam logic [KS_DATA_WIDTH-1:0] MIN_P = KS_DATA_WIDTH'(KS_MIN_LENGTH);

  typedef enum logic [1:0] {IDLE, LOAD, PLUCK, WAIT} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d, term;
  logic [STEP_AW-1:0]       step_q, step_d;
  logic [KS_DATA_WIDTH-1:0] period_q, period_d, p, p_clamp;
  logic                     pluck_q, pluck_d, rest;
  logic [KS_DATA_WIDTH-1:0] tbl_q [NS];
  logic [KS_DATA_WIDTH-1:0] tbl_d [NS];

  always_comb begin
    rest    = tbl_q[step_q][KS_DATA_WIDTH-1];
    p       = KS_DATA_WIDTH'(tbl_q[step_q][5:0]);
    p_clamp = p < MIN_P ? MIN_P : p > MAX_P ? MAX_P : p;
    // Step length is (tempo+1)*16 ticks, so the terminal count is tempo with four ones appended.
    term     = {tempo, 4'hF};
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    period_d = period_q;
    pluck_d  = pluck_q;
    tbl_d    = tbl_q;
    if (tbl_we) tbl_d[tbl_addr] = tbl_wdata;
    if (!seq_en) begin
      state_d = IDLE;
      pluck_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = LOAD;
          step_d  = '0;
          cnt_d   = '0;
        end
        LOAD: begin
          state_d  = rest ? WAIT : PLUCK;
          period_d = rest ? period_q : p_clamp;
        end
        PLUCK: begin
          pluck_d = 1'b1;
          state_d = WAIT;
        end
        default: begin
          pluck_d = 1'b0;
          if (sample_tick) begin
            if (cnt_q >= term) begin
              cnt_d   = '0;
              step_d  = step_q >= last_step ? '0 : step_q + STEP_AW'(1);
              state_d = LOAD;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      step_q   <= '0;
      period_q <= MAX_P;
      pluck_q  <= 1'b0;
      tbl_q    <= '{default: REST_ENTRY};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      period_q <= period_d;
      pluck_q  <= pluck_d;
      tbl_q    <= tbl_d;
    end
  end

  assign ks_period = period_q;
  assign ks_pluck  = pluck_q;
  assign step_idx  = step_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_ks_note_sequencer.sv
// tb_ks_note_sequencer: directed table-driven and sequence checks for ks_note_sequencer.
module tb_ks_note_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seq_en = 1'b0;
  logic       sample_tick = 1'b0;
  logic [7:0] tempo = '0;
  logic [2:0] last_step = '0;
  logic       tbl_we = 1'b0;
  logic [2:0] tbl_addr = '0;
  logic [7:0] tbl_wdata = '0;
  logic [7:0] ks_period;
  logic       ks_pluck;
  logic [2:0] step_idx;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  ks_note_sequencer dut (
    .clk(clk), .rst_n(rst_n), .seq_en(seq_en), .sample_tick(sample_tick),
    .tempo(tempo), .last_step(last_step), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata), .ks_period(ks_period), .ks_pluck(ks_pluck),
    .step_idx(step_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] entry;
    logic [7:0] period;
    logic       pluck;
  } vec_t;

  vec_t vecs[10];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    seq_en = 1'b0;
    sample_tick = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    tbl_we = 1'b1;
    tbl_addr = a;
    tbl_wdata = d;
    tick(1);
    tbl_we = 1'b0;
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      sample_tick = 1'b1;
      tick(1);
      sample_tick = 1'b0;
    end
  endtask

  initial begin
    int plucks, max_step, wraps;
    logic [2:0] prev;
    vecs[0] = '{8'h20, 8'h20, 1'b1};
    vecs[1] = '{8'h3F, 8'd48, 1'b1};
    vecs[2] = '{8'h01, 8'd2,  1'b1};
    vecs[3] = '{8'h95, 8'h30, 1'b0};
    vecs[4] = '{8'h00, 8'd2,  1'b1};
    vecs[5] = '{8'h30, 8'd48, 1'b1};
    vecs[6] = '{8'h31, 8'd48, 1'b1};
    vecs[7] = '{8'h02, 8'd2,  1'b1};
    vecs[8] = '{8'h70, 8'd48, 1'b1};
    vecs[9] = '{8'h45, 8'd5,  1'b1};

    tick(1);
    do_reset();
    chk("reset period", ks_period, 8'h30);
    chk("reset pluck", ks_pluck, 0);
    chk("reset busy", busy, 0);
    chk("reset step", step_idx, 0);

    // Unprogrammed table: all rests, steps cycle 0..2
    last_step = 3'd2;
    tempo = 8'd0;
    seq_en = 1'b1;
    sample_tick = 1'b1;
    plucks = 0;
    max_step = 0;
    wraps = 0;
    prev = 3'd0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (ks_pluck) plucks++;
      if (int'(step_idx) > max_step) max_step = int'(step_idx);
      if (prev == 3'd2 && step_idx == 3'd0) wraps++;
      prev = step_idx;
    end
    sample_tick = 1'b0;
    chk("rest no pluck", plucks, 0);
    chk("rest max step", max_step, 2);
    chk("rest wraps", int'(wraps >= 2), 1);
    chk("rest period held", ks_period, 8'h30);

    // Clamp / rest vectors
    for (int i = 0; i < 10; i++) begin
      do_reset();
      wr(3'd0, vecs[i].entry);
      last_step = 3'd0;
      tempo = 8'd0;
      seq_en = 1'b1;
      tick(2);
      chk($sformatf("vec%0d pre pluck", i), ks_pluck, 0);
      chk($sformatf("vec%0d pre period", i), ks_period, vecs[i].period);
      tick(1);
      chk($sformatf("vec%0d pluck", i), ks_pluck, vecs[i].pluck);
      chk($sformatf("vec%0d period", i), ks_period, vecs[i].period);
      tick(1);
      chk($sformatf("vec%0d pluck end", i), ks_pluck, 0);
    end

    // Basic two-step pattern
    do_reset();
    wr(3'd0, 8'h20);
    wr(3'd1, 8'h10);
    last_step = 3'd1;
    tempo = 8'd0;
    seq_en = 1'b1;
    tick(3);
    chk("basic p0 pluck", ks_pluck, 1);
    chk("basic p0 period", ks_period, 8'h20);
    pulses(15);
    chk("basic 15 step", step_idx, 0);
    chk("basic 15 pluck", ks_pluck, 0);
    pulses(1);
    chk("basic 16 step", step_idx, 1);
    tick(1);
    chk("basic p1 period", ks_period, 8'h10);
    chk("basic p1 early", ks_pluck, 0);
    tick(1);
    chk("basic p1 pluck", ks_pluck, 1);
    pulses(16);
    chk("basic wrap step", step_idx, 0);
    tick(2);
    chk("basic p2 pluck", ks_pluck, 1);
    chk("basic p2 period", ks_period, 8'h20);

    // Tempo lowered below current count
    do_reset();
    wr(3'd0, 8'h20);
    wr(3'd1, 8'h10);
    last_step = 3'd1;
    tempo = 8'd3;
    seq_en = 1'b1;
    tick(3);
    pulses(40);
    chk("tempo 40 step", step_idx, 0);
    tempo = 8'd0;
    pulses(1);
    chk("tempo adv step", step_idx, 1);
    tick(2);
    chk("tempo pluck", ks_pluck, 1);
    chk("tempo period", ks_period, 8'h10);

    // Same-cycle write and load read
    do_reset();
    wr(3'd0, 8'h20);
    last_step = 3'd0;
    seq_en = 1'b1;
    tick(1);
    tbl_we = 1'b1;
    tbl_addr = 3'd0;
    tbl_wdata = 8'h10;
    tick(1);
    tbl_we = 1'b0;
    chk("rw old period", ks_period, 8'h20);
    tick(1);
    pulses(16);
    tick(2);
    chk("rw new pluck", ks_pluck, 1);
    chk("rw new period", ks_period, 8'h10);

    // Disable at step 2, then restart
    do_reset();
    wr(3'd0, 8'h20);
    wr(3'd1, 8'h10);
    wr(3'd2, 8'h18);
    last_step = 3'd3;
    tempo = 8'd0;
    seq_en = 1'b1;
    tick(3);
    pulses(16);
    tick(2);
    pulses(16);
    tick(2);
    chk("dis s2 pluck", ks_pluck, 1);
    chk("dis s2 period", ks_period, 8'h18);
    pulses(5);
    seq_en = 1'b0;
    tick(1);
    chk("dis busy", busy, 0);
    chk("dis step", step_idx, 2);
    chk("dis period", ks_period, 8'h18);
    seq_en = 1'b1;
    tick(1);
    chk("re step", step_idx, 0);
    chk("re busy", busy, 1);
    tick(2);
    chk("re pluck", ks_pluck, 1);
    chk("re period", ks_period, 8'h20);

    // Reset while in PLUCK
    do_reset();
    wr(3'd0, 8'h20);
    last_step = 3'd0;
    seq_en = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    chk("rstp pluck", ks_pluck, 0);
    chk("rstp period", ks_period, 8'h30);
    chk("rstp busy", busy, 0);
    chk("rstp step", step_idx, 0);
    rst_n = 1'b1;
    tick(1);
    chk("rstp busy2", busy, 1);
    tick(2);
    chk("rstp tbl cleared", ks_pluck, 0);
    chk("rstp period2", ks_period, 8'h30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
